// File: rtl/tt08_morse_pkg.sv
// Shared Morse constants, decoder state enum, ROM response type, WPM/timebase math and the
// 7-segment font used by both the keyer and the decoder.
package tt08_morse_pkg;

    localparam int DAH_TH    = 32;   // sub-ticks: 2 dits
    localparam int CHAR_TH   = 32;   // sub-ticks: 2 dits
    localparam int WORD_TH   = 80;   // sub-ticks: 5 dits
    localparam int GLITCH_TH = 2;
    localparam int MARK_MAX  = 63;
    localparam int GAP_MAX   = 127;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_GAP_ELEM,
        S_GAP_WORD
    } dec_state_t;

    typedef struct packed {
        logic       hit;
        logic [7:0] ascii;
    } rom_rsp_t;

    function automatic int wpm_of(input logic [3:0] sel);
        return 5 + 2 * int'(sel);
    endfunction

    // Clocks per 1/16 dit: dit = 1.2 s / WPM, so 1.2/16 = 3/40.
    function automatic int subtick_clks(input int clk_hz, input logic [3:0] sel);
        int n;
        n = (3 * clk_hz) / (40 * wpm_of(sel));
        return (n < 1) ? 1 : n;
    endfunction

    // Active-high GFEDCBA; anything without a glyph shows blank.
    function automatic logic [6:0] seg_font(input logic [7:0] c);
        case (c)
            8'h30: return 7'h3F;  8'h31: return 7'h06;  8'h32: return 7'h5B;
            8'h33: return 7'h4F;  8'h34: return 7'h66;  8'h35: return 7'h6D;
            8'h36: return 7'h7D;  8'h37: return 7'h07;  8'h38: return 7'h7F;
            8'h39: return 7'h6F;
            8'h41: return 7'h77;  8'h42: return 7'h7C;  8'h43: return 7'h39;
            8'h44: return 7'h5E;  8'h45: return 7'h79;  8'h46: return 7'h71;
            8'h47: return 7'h3D;  8'h48: return 7'h76;  8'h49: return 7'h30;
            8'h4A: return 7'h1E;  8'h4B: return 7'h75;  8'h4C: return 7'h38;
            8'h4D: return 7'h37;  8'h4E: return 7'h54;  8'h4F: return 7'h3F;
            8'h50: return 7'h73;  8'h51: return 7'h67;  8'h52: return 7'h50;
            8'h53: return 7'h6D;  8'h54: return 7'h78;  8'h55: return 7'h3E;
            8'h56: return 7'h1C;  8'h57: return 7'h2A;  8'h58: return 7'h64;
            8'h59: return 7'h6E;  8'h5A: return 7'h5B;
            8'h3F: return 7'h53;  8'h2E: return 7'h08;  8'h2C: return 7'h0C;
            8'h2F: return 7'h52;  8'h3D: return 7'h48;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/tt08_morse_char_rom.sv
// Combinational Morse lookup: element count plus dit/dah pattern (first element in the MSB
// of the len-bit field, dah = 1) to ASCII.
module tt08_morse_char_rom
    import tt08_morse_pkg::*;
(
    input  logic [2:0] len,
    input  logic [5:0] bits,
    output rom_rsp_t   rsp
);

    always_comb begin
        rsp.hit   = 1'b1;
        rsp.ascii = 8'h00;
        case ({len, bits})
            {3'd2, 6'b000001}: rsp.ascii = 8'h41;  // A .-
            {3'd4, 6'b001000}: rsp.ascii = 8'h42;  // B -...
            {3'd4, 6'b001010}: rsp.ascii = 8'h43;  // C -.-.
            {3'd3, 6'b000100}: rsp.ascii = 8'h44;
            {3'd1, 6'b000000}: rsp.ascii = 8'h45;
            {3'd4, 6'b000010}: rsp.ascii = 8'h46;
            {3'd3, 6'b000110}: rsp.ascii = 8'h47;
            {3'd4, 6'b000000}: rsp.ascii = 8'h48;
            {3'd2, 6'b000000}: rsp.ascii = 8'h49;
            {3'd4, 6'b000111}: rsp.ascii = 8'h4A;
            {3'd3, 6'b000101}: rsp.ascii = 8'h4B;
            {3'd4, 6'b000100}: rsp.ascii = 8'h4C;
            {3'd2, 6'b000011}: rsp.ascii = 8'h4D;
            {3'd2, 6'b000010}: rsp.ascii = 8'h4E;
            {3'd3, 6'b000111}: rsp.ascii = 8'h4F;
            {3'd4, 6'b000110}: rsp.ascii = 8'h50;
            {3'd4, 6'b001101}: rsp.ascii = 8'h51;
            {3'd3, 6'b000010}: rsp.ascii = 8'h52;
            {3'd3, 6'b000000}: rsp.ascii = 8'h53;
            {3'd1, 6'b000001}: rsp.ascii = 8'h54;
            {3'd3, 6'b000001}: rsp.ascii = 8'h55;
            {3'd4, 6'b000001}: rsp.ascii = 8'h56;
            {3'd3, 6'b000011}: rsp.ascii = 8'h57;
            {3'd4, 6'b001001}: rsp.ascii = 8'h58;
            {3'd4, 6'b001011}: rsp.ascii = 8'h59;
            {3'd4, 6'b001100}: rsp.ascii = 8'h5A;
            {3'd5, 6'b011111}: rsp.ascii = 8'h30;
            {3'd5, 6'b001111}: rsp.ascii = 8'h31;
            {3'd5, 6'b000111}: rsp.ascii = 8'h32;
            {3'd5, 6'b000011}: rsp.ascii = 8'h33;
            {3'd5, 6'b000001}: rsp.ascii = 8'h34;
            {3'd5, 6'b000000}: rsp.ascii = 8'h35;
            {3'd5, 6'b010000}: rsp.ascii = 8'h36;
            {3'd5, 6'b011000}: rsp.ascii = 8'h37;
            {3'd5, 6'b011100}: rsp.ascii = 8'h38;
            {3'd5, 6'b011110}: rsp.ascii = 8'h39;
            {3'd5, 6'b010010}: rsp.ascii = 8'h2F;  // /
            {3'd5, 6'b010001}: rsp.ascii = 8'h3D;  // =
            {3'd6, 6'b010101}: rsp.ascii = 8'h2E;  // .
            {3'd6, 6'b110011}: rsp.ascii = 8'h2C;  // ,
            {3'd6, 6'b001100}: rsp.ascii = 8'h3F;  // ?
            default:           rsp.hit   = 1'b0;
        endcase
    end

endmodule

// File: rtl/tt08_morse_decoder.sv
// Morse receiver: synchronizes and glitch-filters the keyed input, times marks and gaps in
// 1/16-dit sub-ticks, and emits decoded ASCII with a strobe and a 7-segment glyph.
module tt08_morse_decoder
    import tt08_morse_pkg::*;
#(
    parameter int CLK_HZ   = 10_000_000,
    parameter int MAX_ELEM = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       morse_i,
    input  logic [3:0] wpm_sel_i,
    output logic [7:0] char_o,
    output logic       char_valid_o,
    output logic       err_o,
    output logic       mark_o,
    output logic [7:0] seven_segment_o
);

    localparam int ELEM_CAP = (MAX_ELEM > 6) ? 6 : MAX_ELEM;
    // Slowest speed (sel = 0) needs the widest prescaler.
    localparam int PRE_W    = $clog2(subtick_clks(CLK_HZ, 4'd0) + 1);

    logic [1:0]       sync_pipe;
    logic             m_s;
    logic [PRE_W-1:0] sub_lut [16];
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [5:0]       mark_cnt;
    logic [6:0]       gap_cnt;
    logic             mark_q;
    logic             qual, mark_end, elem_dah;
    logic [2:0]       len_q;
    logic [5:0]       bits_q;
    logic             ovf_q;
    dec_state_t       state_q, state_d;
    logic             emit, emit_err, char_done;
    logic [7:0]       emit_char;
    rom_rsp_t         rom_rsp;
    logic [7:0]       char_q;
    logic [6:0]       seg_q;
    logic             valid_q, err_q;

    for (genvar gi = 0; gi < 16; gi++) begin : g_lut
        assign sub_lut[gi] = PRE_W'(subtick_clks(CLK_HZ, 4'(gi)) - 1);
    end

    assign m_s      = sync_pipe[1];
    assign tick     = (pre_cnt == '0);
    assign qual     = m_s && !mark_q && tick && (mark_cnt >= 6'(GLITCH_TH - 1));
    assign mark_end = mark_q && !m_s;
    assign elem_dah = (mark_cnt >= 6'(DAH_TH));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_pipe <= '0;
            pre_cnt   <= '0;
            mark_cnt  <= '0;
            gap_cnt   <= '0;
            mark_q    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], morse_i};
            pre_cnt   <= tick ? sub_lut[wpm_sel_i] : pre_cnt - 1'b1;
            if (!m_s)
                mark_cnt <= '0;
            else if (tick && mark_cnt != 6'(MARK_MAX))
                mark_cnt <= mark_cnt + 6'd1;
            // Unqualified marks leave the gap count running.
            if (qual)
                gap_cnt <= '0;
            else if (!mark_q && tick && gap_cnt != 7'(GAP_MAX))
                gap_cnt <= gap_cnt + 7'd1;
            if (qual)
                mark_q <= 1'b1;
            else if (mark_end)
                mark_q <= 1'b0;
        end
    end

    tt08_morse_char_rom u_rom (
        .len  (len_q),
        .bits (bits_q),
        .rsp  (rom_rsp)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        emit      = 1'b0;
        emit_err  = 1'b0;
        emit_char = 8'h00;
        char_done = 1'b0;
        case (state_q)
            S_IDLE: if (qual) state_d = S_MARK;
            S_MARK: if (mark_end) state_d = S_GAP_ELEM;
            S_GAP_ELEM: begin
                if (qual) begin
                    state_d = S_MARK;
                end else if (gap_cnt >= 7'(CHAR_TH)) begin
                    state_d   = S_GAP_WORD;
                    emit      = 1'b1;
                    char_done = 1'b1;
                    if (rom_rsp.hit && !ovf_q) begin
                        emit_char = rom_rsp.ascii;
                    end else begin
                        emit_char = 8'h3F;
                        emit_err  = 1'b1;
                    end
                end
            end
            S_GAP_WORD: begin
                if (qual) begin
                    state_d = S_MARK;
                end else if (gap_cnt >= 7'(WORD_TH)) begin
                    state_d   = S_IDLE;
                    emit      = 1'b1;
                    emit_char = 8'h20;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Element buffer: first element ends up in the MSB of the len-bit field.
    always_ff @(posedge clk_i) begin
        if (rst_i || char_done) begin
            len_q  <= '0;
            bits_q <= '0;
            ovf_q  <= 1'b0;
        end else if (mark_end) begin
            if (len_q == 3'(ELEM_CAP)) begin
                ovf_q <= 1'b1;
            end else begin
                bits_q <= {bits_q[4:0], elem_dah};
                len_q  <= len_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            char_q  <= '0;
            seg_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= emit;
            err_q   <= emit && emit_err;
            if (emit) begin
                char_q <= emit_char;
                seg_q  <= seg_font(emit_char);
            end
        end
    end

    assign char_o          = char_q;
    assign char_valid_o    = valid_q;
    assign err_o           = err_q;
    assign mark_o          = mark_q;
    assign seven_segment_o = {mark_q, seg_q};

endmodule

// File: tb/tb_tt08_morse_decoder.sv
// Scoreboard bench for tt08_morse_decoder; durations are expressed in sub-ticks so the
// scenarios scale with the chosen CLK_HZ.
module tb_tt08_morse_decoder;

    localparam int CLK_HZ = 1600;
    localparam int SUB    = 24;          // 3*1600/(40*5)
    localparam int DIT    = 16 * SUB;
    localparam int DAH    = 3 * DIT;
    localparam int SUB35  = 3;           // 3*1600/(40*35) = 3.43 -> 3
    localparam int DIT35  = 16 * SUB35;
    localparam int DAH35  = 3 * DIT35;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       morse_i = 1'b0;
    logic [3:0] wpm_sel_i = 4'd0;
    logic [7:0] char_o, seven_segment_o;
    logic       char_valid_o, err_o, mark_o;

    typedef struct {
        logic [7:0] ch;
        logic       err;
        logic [6:0] seg;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   n_strobe = 0;
    int   last_emit_cyc = 0;
    int   cyc = 0;

    tt08_morse_decoder #(.CLK_HZ(CLK_HZ), .MAX_ELEM(6)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .morse_i         (morse_i),
        .wpm_sel_i       (wpm_sel_i),
        .char_o          (char_o),
        .char_valid_o    (char_valid_o),
        .err_o           (err_o),
        .mark_o          (mark_o),
        .seven_segment_o (seven_segment_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic v, input int n);
        morse_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        morse_i = 1'b0;
        rst_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (char_valid_o === 1'b1) begin
                n_strobe++;
                last_emit_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_strobe: got char_o=%h err_o=%b, required no strobe",
                             char_o, err_o);
                end else begin
                    passed++;
                    e = exp_q.pop_front();
                    checks++;
                    if (char_o !== e.ch) $display("FAIL strobe_char: got %h, required %h", char_o, e.ch);
                    else passed++;
                    checks++;
                    if (err_o !== e.err) $display("FAIL strobe_err: got %b, required %b (char %h)", err_o, e.err, e.ch);
                    else passed++;
                    checks++;
                    if (seven_segment_o[6:0] !== e.seg)
                        $display("FAIL strobe_seg: got %h, required %h (char %h)", seven_segment_o[6:0], e.seg, e.ch);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (char_o !== 8'h00) $display("FAIL rst_char: got %h, required 00", char_o); else passed++;
        checks++; if (char_valid_o !== 1'b0) $display("FAIL rst_valid: got %b, required 0", char_valid_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b, required 0", err_o); else passed++;
        checks++; if (mark_o !== 1'b0) $display("FAIL rst_mark: got %b, required 0", mark_o); else passed++;
        checks++; if (seven_segment_o !== 8'h00) $display("FAIL rst_seg: got %h, required 00", seven_segment_o); else passed++;
    endtask

    task automatic test_letter_a();
        int s0;
        do_reset();
        s0 = n_strobe;
        exp_q.push_back('{8'h41, 1'b0, 7'h77});
        drive(1'b1, DIT); drive(1'b0, DIT); drive(1'b1, DAH / 2);
        @(negedge clk);
        checks++; if (mark_o !== 1'b1) $display("FAIL a_mark_o: got %b, required 1", mark_o); else passed++;
        checks++; if (seven_segment_o[7] !== 1'b1) $display("FAIL a_dp: got %b, required 1", seven_segment_o[7]); else passed++;
        drive(1'b1, DAH / 2); drive(1'b0, DAH);
        checks++; if (exp_q.size() != 0) $display("FAIL a_pending: got %0d left, required 0", exp_q.size()); else passed++;
        checks++; if (n_strobe - s0 != 1) $display("FAIL a_strobes: got %0d, required 1", n_strobe - s0); else passed++;
        checks++; if (char_o !== 8'h41) $display("FAIL a_hold_char: got %h, required 41", char_o); else passed++;
        checks++; if (seven_segment_o !== 8'h77) $display("FAIL a_hold_seg: got %h, required 77", seven_segment_o); else passed++;
    endtask

    task automatic test_word_space();
        int s0;
        do_reset();
        s0 = n_strobe;
        exp_q.push_back('{8'h53, 1'b0, 7'h6D});
        exp_q.push_back('{8'h20, 1'b0, 7'h00});
        drive(1'b1, DIT); drive(1'b0, DIT);
        drive(1'b1, DIT); drive(1'b0, DIT);
        drive(1'b1, DIT); drive(1'b0, 3000);
        drive(1'b0, 3000);
        checks++; if (exp_q.size() != 0) $display("FAIL s_pending: got %0d left, required 0", exp_q.size()); else passed++;
        checks++; if (n_strobe - s0 != 2) $display("FAIL s_strobes: got %0d, required 2", n_strobe - s0); else passed++;
    endtask

    task automatic test_overflow();
        int s0;
        do_reset();
        s0 = n_strobe;
        exp_q.push_back('{8'h3F, 1'b1, 7'h53});
        exp_q.push_back('{8'h45, 1'b0, 7'h79});
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, DIT);
            drive(1'b0, (i == 6) ? DAH : DIT);
        end
        drive(1'b1, DIT); drive(1'b0, DAH);
        checks++; if (exp_q.size() != 0) $display("FAIL ovf_pending: got %0d left, required 0", exp_q.size()); else passed++;
        checks++; if (n_strobe - s0 != 2) $display("FAIL ovf_strobes: got %0d, required 2", n_strobe - s0); else passed++;
    endtask

    task automatic test_glitch();
        int s0, t0, dt;
        logic seen;
        do_reset();
        s0 = n_strobe;
        seen = 1'b0;
        morse_i = 1'b1;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; seen |= mark_o; end
        morse_i = 1'b0;
        for (int i = 0; i < 8; i++) begin @(posedge clk); #1; seen |= mark_o; end
        drive(1'b0, 2500);
        checks++; if (seen !== 1'b0) $display("FAIL glitch_idle_mark: got %b, required 0", seen); else passed++;
        checks++; if (n_strobe != s0) $display("FAIL glitch_idle_strobes: got %0d, required 0", n_strobe - s0); else passed++;
        exp_q.push_back('{8'h45, 1'b0, 7'h79});
        drive(1'b1, DIT);
        t0 = cyc;
        drive(1'b0, DIT);
        morse_i = 1'b1;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; seen |= mark_o; end
        drive(1'b0, DAH - DIT - 20);
        dt = last_emit_cyc - t0;
        checks++; if (seen !== 1'b0) $display("FAIL glitch_gap_mark: got %b, required 0", seen); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL glitch_pending: got %0d left, required 0", exp_q.size()); else passed++;
        checks++;
        if (dt < 730 || dt > 800) $display("FAIL glitch_emit_time: got %0d clk after mark end, required 730..800", dt);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int s0;
        do_reset();
        s0 = n_strobe;
        exp_q.push_back('{8'h54, 1'b0, 7'h78});
        drive(1'b1, DAH); drive(1'b0, DAH);
        drive(1'b1, DIT); drive(1'b0, DIT);
        drive(1'b1, DIT); drive(1'b0, 100);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++; if (char_o !== 8'h00) $display("FAIL mrst_char: got %h, required 00", char_o); else passed++;
        checks++; if (seven_segment_o !== 8'h00) $display("FAIL mrst_seg: got %h, required 00", seven_segment_o); else passed++;
        checks++; if (char_valid_o !== 1'b0) $display("FAIL mrst_valid: got %b, required 0", char_valid_o); else passed++;
        checks++; if (err_o !== 1'b0) $display("FAIL mrst_err: got %b, required 0", err_o); else passed++;
        checks++; if (mark_o !== 1'b0) $display("FAIL mrst_mark: got %b, required 0", mark_o); else passed++;
        exp_q.push_back('{8'h54, 1'b0, 7'h78});
        drive(1'b1, DAH); drive(1'b0, DAH);
        checks++; if (exp_q.size() != 0) $display("FAIL mrst_pending: got %0d left, required 0", exp_q.size()); else passed++;
        checks++; if (n_strobe - s0 != 2) $display("FAIL mrst_strobes: got %0d, required 2", n_strobe - s0); else passed++;
    endtask

    task automatic test_fast_wpm();
        int s0;
        wpm_sel_i = 4'd15;
        do_reset();
        s0 = n_strobe;
        exp_q.push_back('{8'h43, 1'b0, 7'h39});
        exp_q.push_back('{8'h20, 1'b0, 7'h00});
        drive(1'b1, DAH35); drive(1'b0, DIT35);
        drive(1'b1, DIT35); drive(1'b0, DIT35);
        drive(1'b1, DAH35); drive(1'b0, DIT35);
        drive(1'b1, DIT35); drive(1'b0, 500);
        checks++; if (exp_q.size() != 0) $display("FAIL fast_pending: got %0d left, required 0", exp_q.size()); else passed++;
        checks++; if (n_strobe - s0 != 2) $display("FAIL fast_strobes: got %0d, required 2", n_strobe - s0); else passed++;
        checks++; if (char_o !== 8'h20) $display("FAIL fast_hold_char: got %h, required 20", char_o); else passed++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_letter_a();
        test_word_space();
        test_overflow();
        test_glitch();
        test_mid_reset();
        test_fast_wpm();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
